fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the decoder. Holds the program counter, issues one word read at a time to instruction memory over a request/ready and data-valid handshake, and presents the fetched word and its PC to decode. Holds the instruction while decode asserts `stall`. Restarts from a new PC on a branch or jump redirect from execute, discarding any in-flight stale fetch.

---
 rtl/fetch_unit_if.sv | 25 ++
 rtl/fetch_unit.sv | 101 ++++++++++
 tb/tb_fetch_unit.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-memory read channel between the fetch stage (master) and imem (slave).
// One request at a time: req/ready handshake for the address, data_valid for the return.
interface fetch_unit_if;
  logic        read_req;
  logic [31:0] addr;
  logic        read_ready;
  logic [31:0] read_data;
  logic        read_data_valid;

  modport master (
    output read_req,
    output addr,
    input  read_ready,
    input  read_data,
    input  read_data_valid
  );

  modport slave (
    input  read_req,
    input  addr,
    output read_ready,
    output read_data,
    output read_data_valid
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, issues one imem read at a time and presents
// the fetched word to decode; redirects restart fetch and drop any stale in-flight read.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc,
  fetch_unit_if.master        imem,
  output logic [31:0]         instr,
  output logic [31:0]         pc,
  output logic                instr_valid
);

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        instr_valid_q, instr_valid_d;
  logic        kill_q, kill_d;
  logic [31:0] target_pc;

  assign target_pc = redirect_pc & 32'hFFFF_FFFC;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    kill_d        = kill_q;
    case (state_q)
      ST_REQ: begin
        // Changing the address here is safe: an unaccepted request has no memory side effect.
        if (redirect) pc_d = target_pc;
        if (imem.read_ready) begin
          state_d = ST_WAIT;
          kill_d  = redirect;
        end
      end
      ST_WAIT: begin
        if (imem.read_data_valid) begin
          if (kill_q || redirect) begin
            kill_d  = 1'b0;
            state_d = ST_REQ;
            if (redirect) pc_d = target_pc;
          end else begin
            instr_d       = imem.read_data;
            instr_valid_d = 1'b1;
            state_d       = ST_HOLD;
          end
        end else if (redirect) begin
          pc_d   = target_pc;
          kill_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          pc_d          = target_pc;
          instr_valid_d = 1'b0;
          state_d       = ST_REQ;
        end else if (!stall) begin
          pc_d          = pc_q + 32'd4;
          instr_valid_d = 1'b0;
          state_d       = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_REQ;
      pc_q          <= RESET_PC_ALIGNED;
      instr_q       <= NOP_INSTR;
      instr_valid_q <= 1'b0;
      kill_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      kill_q        <= kill_d;
    end
  end

  assign imem.read_req = (state_q == ST_REQ);
  assign imem.addr     = pc_q;
  assign pc            = pc_q;
  assign instr_valid   = instr_valid_q;
  assign instr         = instr_valid_q ? instr_q : NOP_INSTR;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a directed cycle table for the documented corner cases, then a
// randomized run against a transaction-level model of PC flow and useful/stale reads.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        instr_valid;

  fetch_unit_if imem_bus ();

  fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (imem_bus.master),
    .instr       (instr),
    .pc          (pc),
    .instr_valid (instr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stl;
    logic        rd;
    logic [31:0] rpc;
    logic        rdy;
    logic        dv;
    logic [31:0] dat;
    logic        chk;
    logic        req;
    logic        vld;
    logic [31:0] pcv;
    logic [31:0] ins;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic add_vec(input logic rst, input logic stl, input logic rd, input logic [31:0] rpc,
                         input logic rdy, input logic dv, input logic [31:0] dat, input logic chk,
                         input logic req, input logic vld, input logic [31:0] pcv,
                         input logic [31:0] ins);
    vec_t v;
    v.rst = rst; v.stl = stl; v.rd = rd; v.rpc = rpc; v.rdy = rdy; v.dv = dv; v.dat = dat;
    v.chk = chk; v.req = req; v.vld = vld; v.pcv = pcv; v.ins = ins;
    vecs.push_back(v);
  endtask

  task automatic apply_stimulus(input vec_t v);
    reset                    = v.rst;
    stall                    = v.stl;
    redirect                 = v.rd;
    redirect_pc              = v.rpc;
    imem_bus.read_ready      = v.rdy;
    imem_bus.read_data_valid = v.dv;
    imem_bus.read_data       = v.dat;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Abstract model state for the random run.
  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_out;
  logic        m_stale;
  logic [31:0] m_acc;
  int          m_cnt;
  int          deliveries;
  logic        req_seen;

  initial begin
    apply_stimulus('{rst:1, stl:0, rd:0, rpc:0, rdy:0, dv:0, dat:0,
                     chk:0, req:0, vld:0, pcv:0, ins:0});

    //       rst stl rd rpc            rdy dv dat           chk req vld pc             instr
    add_vec(1, 0, 0, 32'h0,          0, 0, 32'h0,          0, 0, 0, 32'h0,          NOP);
    add_vec(0, 0, 0, 32'h0,          1, 0, 32'h0,          1, 1, 0, 32'h100,        NOP);
    add_vec(0, 0, 0, 32'h0,          0, 1, 32'h93,         1, 0, 0, 32'h100,        NOP);
    for (int i = 0; i < 5; i++)
      add_vec(0, 1, 0, 32'h0,        0, 0, 32'h0,          1, 0, 1, 32'h100,        32'h93);
    add_vec(0, 0, 0, 32'h0,          0, 0, 32'h0,          1, 0, 1, 32'h100,        32'h93);
    for (int i = 0; i < 4; i++)
      add_vec(0, 0, 0, 32'h0,        0, 0, 32'h0,          1, 1, 0, 32'h104,        NOP);
    add_vec(0, 0, 0, 32'h0,          1, 0, 32'h0,          1, 1, 0, 32'h104,        NOP);
    add_vec(0, 0, 1, 32'h203,        0, 0, 32'h0,          1, 0, 0, 32'h104,        NOP);
    add_vec(0, 0, 0, 32'h0,          0, 0, 32'h0,          1, 0, 0, 32'h200,        NOP);
    add_vec(0, 0, 0, 32'h0,          0, 1, 32'hDEAD_BEEF,  1, 0, 0, 32'h200,        NOP);
    add_vec(0, 0, 1, 32'h300,        1, 0, 32'h0,          1, 1, 0, 32'h200,        NOP);
    add_vec(0, 0, 0, 32'h0,          0, 1, 32'h0000_0BAD,  1, 0, 0, 32'h300,        NOP);
    add_vec(0, 0, 0, 32'h0,          1, 0, 32'h0,          1, 1, 0, 32'h300,        NOP);
    add_vec(0, 0, 0, 32'h0,          0, 1, 32'h00A0_0093,  1, 0, 0, 32'h300,        NOP);
    add_vec(0, 1, 1, 32'hFFFF_FFFC,  0, 0, 32'h0,          1, 0, 1, 32'h300,        32'h00A0_0093);
    add_vec(0, 0, 0, 32'h0,          1, 0, 32'h0,          1, 1, 0, 32'hFFFF_FFFC,  NOP);
    add_vec(0, 0, 0, 32'h0,          0, 1, 32'h11,         1, 0, 0, 32'hFFFF_FFFC,  NOP);
    add_vec(0, 0, 0, 32'h0,          0, 0, 32'h0,          1, 0, 1, 32'hFFFF_FFFC,  32'h11);
    add_vec(0, 0, 0, 32'h0,          1, 0, 32'h0,          1, 1, 0, 32'h0,          NOP);
    add_vec(1, 0, 0, 32'h0,          0, 0, 32'h0,          1, 0, 0, 32'h0,          NOP);
    add_vec(0, 0, 0, 32'h0,          0, 1, 32'h77,         1, 1, 0, 32'h100,        NOP);
    add_vec(0, 0, 1, 32'h40,         0, 0, 32'h0,          1, 1, 0, 32'h100,        NOP);
    add_vec(0, 0, 0, 32'h0,          0, 0, 32'h0,          1, 1, 0, 32'h40,         NOP);

    foreach (vecs[i]) begin
      @(negedge clk);
      if (vecs[i].chk) begin
        check_output($sformatf("vec%0d_req", i),   {31'b0, imem_bus.read_req}, {31'b0, vecs[i].req});
        check_output($sformatf("vec%0d_addr", i),  imem_bus.addr,              vecs[i].pcv);
        check_output($sformatf("vec%0d_pc", i),    pc,                         vecs[i].pcv);
        check_output($sformatf("vec%0d_valid", i), {31'b0, instr_valid},       {31'b0, vecs[i].vld});
        check_output($sformatf("vec%0d_instr", i), instr,                      vecs[i].ins);
      end
      apply_stimulus(vecs[i]);
    end

    // Reset while a read is in flight, then bounded wait for the first request.
    @(negedge clk);
    imem_bus.read_ready = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    imem_bus.read_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    imem_bus.read_data_valid = 1'b1;
    imem_bus.read_data = 32'hCAFE_F00D;
    begin
      int waited;
      waited = 0;
      while (!imem_bus.read_req && waited < 8) begin
        @(negedge clk);
        waited++;
      end
      check_output("first_req_latency", waited, 0);
      check_output("first_req_addr", imem_bus.addr, RST_PC);
    end
    @(negedge clk);
    imem_bus.read_data_valid = 1'b0;
    check_output("late_data_ignored_valid", {31'b0, instr_valid}, 32'd0);
    check_output("late_data_ignored_req", {31'b0, imem_bus.read_req}, 32'd1);

    // Randomized run.
    reset = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    @(negedge clk);
    reset = 1'b0;
    m_pc = RST_PC; m_valid = 1'b0; m_out = 1'b0; m_stale = 1'b0; m_acc = 32'h0; m_cnt = 0;
    deliveries = 0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic useful;
      logic [31:0] pc_before;
      @(negedge clk);
      req_seen = imem_bus.read_req;
      check_output("rnd_req",   {31'b0, imem_bus.read_req}, {31'b0, (!m_valid && !m_out)});
      check_output("rnd_addr",  imem_bus.addr,              m_pc);
      check_output("rnd_pc",    pc,                         m_pc);
      check_output("rnd_valid", {31'b0, instr_valid},       {31'b0, m_valid});
      check_output("rnd_instr", instr,                      m_valid ? mem_word(m_pc) : NOP);

      stall    = ($urandom_range(0, 2) == 0);
      redirect = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 3))
        0:       redirect_pc = 32'hFFFF_FFFC | $urandom_range(0, 3);
        1:       redirect_pc = 32'hFFFF_FFF0 | $urandom_range(0, 15);
        default: redirect_pc = $urandom;
      endcase
      imem_bus.read_ready = ($urandom_range(0, 2) != 0);
      if (m_out) begin
        imem_bus.read_data_valid = (m_cnt == 0);
        imem_bus.read_data       = mem_word(m_acc);
      end else begin
        imem_bus.read_data_valid = ($urandom_range(0, 7) == 0);
        imem_bus.read_data       = $urandom;
      end

      @(posedge clk);
      pc_before = m_pc;
      useful = m_out && imem_bus.read_data_valid && !m_stale && !redirect;
      if (useful) deliveries++;
      if (redirect)                m_pc = redirect_pc & 32'hFFFF_FFFC;
      else if (m_valid && !stall)  m_pc = m_pc + 32'd4;
      if (m_valid && (redirect || !stall)) m_valid = 1'b0;
      else if (useful)                     m_valid = 1'b1;
      if (m_out && imem_bus.read_data_valid) begin
        m_out = 1'b0;
      end else if (m_out) begin
        m_cnt--;
        if (redirect) m_stale = 1'b1;
      end
      if (req_seen && imem_bus.read_ready) begin
        m_out   = 1'b1;
        m_stale = redirect;
        m_acc   = pc_before;
        m_cnt   = $urandom_range(0, 3);
      end
    end
    check_output("rnd_deliveries_min", {31'b0, (deliveries >= 100)}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
